// File: rtl/demux_pkg.sv
// Shared constants, types and helpers for the 1-to-N stream demultiplexer.
package demux_pkg;

    localparam int DEMUX_MAX_OUT = 16;
    localparam int DEMUX_CNT_W   = 8;

    typedef logic [DEMUX_CNT_W-1:0] drop_cnt_t;

    // True when a (zero-extended) select value addresses an existing channel.
    function automatic logic sel_in_range(input logic [31:0] sel, input logic [31:0] n);
        return (sel < n);
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry valid/ready register slot. A load always wins over a drain on the
// same edge, which gives bubble-free back-to-back delivery. The parent only
// asserts load while free_o is high, so an occupied slot is never overwritten.
module demux_slot
    import demux_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] d_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] q_o,
    output logic              free_o
);

    logic              valid_q;
    logic              valid_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;

    // Next state: reload keeps valid high, otherwise a handshake empties the slot.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = d_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Slot register; data only changes on a load, so it is stable while empty.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign q_o     = data_q;
    assign free_o  = ~valid_q | ready_i;

endmodule

// File: rtl/demux_1ton_stream.sv
// Routes one valid/ready stream to one of N_OUT registered output slots, or to
// all of them at once on a broadcast beat. Beats addressed beyond the last
// channel are accepted, discarded, flagged and counted.
module demux_1ton_stream
    import demux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int N_OUT  = 4,
    parameter int SEL_W  = $clog2(N_OUT),
    parameter int CNT_W  = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [DATA_W-1:0]       in_data_i,
    input  logic [SEL_W-1:0]        in_sel_i,
    input  logic                    in_bcast_i,
    output logic [N_OUT-1:0]        out_valid_o,
    input  logic [N_OUT-1:0]        out_ready_i,
    output logic [N_OUT*DATA_W-1:0] out_data_o,
    output logic                    err_pulse_o,
    output logic [CNT_W-1:0]        drop_cnt_o
);

    logic [N_OUT-1:0] slot_free;
    logic [N_OUT-1:0] sel_hit;
    logic [N_OUT-1:0] slot_load;
    logic             sel_ok;
    logic             route_ready;
    logic             accept;
    logic             drop_ev;
    logic             err_q;
    logic             err_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Select decode: one-hot channel hit plus range check (N_OUT need not be 2^k).
    always_comb begin
        sel_ok = sel_in_range(32'(in_sel_i), 32'(N_OUT));
        for (int k = 0; k < N_OUT; k++) begin
            sel_hit[k] = (32'(in_sel_i) == 32'(k));
        end
    end

    // Ready depends only on slot occupancy and out_ready, never on in_valid.
    always_comb begin
        if (in_bcast_i) begin
            route_ready = &slot_free;
        end else if (sel_ok) begin
            route_ready = |(sel_hit & slot_free);
        end else begin
            route_ready = 1'b1;
        end
    end

    // Holding ready low during reset keeps an in-flight beat from being taken.
    assign in_ready_o = rst_n_i & route_ready;
    assign accept     = in_valid_i & in_ready_o;
    assign drop_ev    = accept & ~in_bcast_i & ~sel_ok;

    // Slot write enables: broadcast is all-or-nothing because ready required every slot free.
    always_comb begin
        slot_load = '0;
        if (accept) begin
            slot_load = in_bcast_i ? {N_OUT{1'b1}} : sel_hit;
        end
    end

    // Drop flag and saturating drop counter next state.
    always_comb begin
        err_d = drop_ev;
        cnt_d = cnt_q;
        if (drop_ev && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Error pulse and drop counter registers.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    assign err_pulse_o = err_q;
    assign drop_cnt_o  = cnt_q;

    for (genvar k = 0; k < N_OUT; k++) begin : g_slot
        demux_slot #(
            .DATA_W (DATA_W)
        ) u_slot (
            .clk_i   (clk_i),
            .rst_n_i (rst_n_i),
            .load_i  (slot_load[k]),
            .d_i     (in_data_i),
            .ready_i (out_ready_i[k]),
            .valid_o (out_valid_o[k]),
            .q_o     (out_data_o[k*DATA_W +: DATA_W]),
            .free_o  (slot_free[k])
        );
    end

endmodule

// File: tb/tb_demux_1ton_stream.sv
module tb_demux_1ton_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Instance A: default 4 channels, directed scenarios.
    logic        a_rst_n, a_in_valid, a_in_ready, a_in_bcast, a_err;
    logic [7:0]  a_in_data, a_drop;
    logic [1:0]  a_in_sel;
    logic [3:0]  a_out_valid, a_out_ready;
    logic [31:0] a_out_data;

    demux_1ton_stream #(.DATA_W(8), .N_OUT(4), .CNT_W(8)) dut_a (
        .clk_i(clk), .rst_n_i(a_rst_n), .in_valid_i(a_in_valid), .in_ready_o(a_in_ready),
        .in_data_i(a_in_data), .in_sel_i(a_in_sel), .in_bcast_i(a_in_bcast),
        .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .out_data_o(a_out_data),
        .err_pulse_o(a_err), .drop_cnt_o(a_drop));

    // Instance B: 3 channels, 2-bit drop counter.
    logic        b_rst_n, b_in_valid, b_in_ready, b_in_bcast, b_err;
    logic [7:0]  b_in_data;
    logic [1:0]  b_in_sel, b_drop;
    logic [2:0]  b_out_valid, b_out_ready;
    logic [23:0] b_out_data;

    demux_1ton_stream #(.DATA_W(8), .N_OUT(3), .CNT_W(2)) dut_b (
        .clk_i(clk), .rst_n_i(b_rst_n), .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
        .in_data_i(b_in_data), .in_sel_i(b_in_sel), .in_bcast_i(b_in_bcast),
        .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .out_data_o(b_out_data),
        .err_pulse_o(b_err), .drop_cnt_o(b_drop));

    // Instance C: 5 channels, random soak.
    localparam int CN = 5;
    logic        c_rst_n, c_in_valid, c_in_ready, c_in_bcast, c_err;
    logic [7:0]  c_in_data, c_drop;
    logic [2:0]  c_in_sel;
    logic [4:0]  c_out_valid, c_out_ready;
    logic [39:0] c_out_data;

    demux_1ton_stream #(.DATA_W(8), .N_OUT(CN), .CNT_W(8)) dut_c (
        .clk_i(clk), .rst_n_i(c_rst_n), .in_valid_i(c_in_valid), .in_ready_o(c_in_ready),
        .in_data_i(c_in_data), .in_sel_i(c_in_sel), .in_bcast_i(c_in_bcast),
        .out_valid_o(c_out_valid), .out_ready_i(c_out_ready), .out_data_o(c_out_data),
        .err_pulse_o(c_err), .drop_cnt_o(c_drop));

    // Reference model for instance C: per-channel queues of beats owed to each consumer.
    logic [7:0] exp_q [CN][$];
    logic       c_err_m  = 1'b0;
    int         c_drop_m = 0;
    logic       soak_on  = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_a();
        a_rst_n = 0; a_in_valid = 0; a_in_data = 0; a_in_sel = 0; a_in_bcast = 0; a_out_ready = '1;
        tick();
        chk("a_ready_in_reset", a_in_ready, 0);
        tick();
        a_rst_n = 1;
        #1;
        chk("a_rst_valid", a_out_valid, 0);
        chk("a_rst_data", a_out_data, 0);
        chk("a_rst_err", a_err, 0);
        chk("a_rst_drop", a_drop, 0);
        chk("a_ready_after_rst", a_in_ready, 1);

        // Each select in turn, consumers always ready.
        for (int s = 0; s < 4; s++) begin
            a_in_valid = 1; a_in_sel = 2'(s); a_in_data = 8'(8'hA0 + s);
            #1;
            chk("t1_ready", a_in_ready, 1);
            tick();
            chk("t1_onehot", a_out_valid, 64'(1 << s));
            chk("t1_data", a_out_data[s*8 +: 8], 64'(8'hA0 + s));
        end
        a_in_valid = 0;
        tick();
        chk("t1_idle", a_out_valid, 0);

        // Backpressure on channel 2.
        a_out_ready = 4'b1011; a_in_valid = 1; a_in_sel = 2; a_in_data = 8'h11;
        #1;
        chk("t2_first_ready", a_in_ready, 1);
        tick();
        chk("t2_slot2_valid", a_out_valid[2], 1);
        chk("t2_slot2_data", a_out_data[23:16], 8'h11);
        a_in_data = 8'h22;
        #1;
        chk("t2_blocked", a_in_ready, 0);
        tick();
        chk("t2_held_data", a_out_data[23:16], 8'h11);
        chk("t2_held_valid", a_out_valid[2], 1);
        a_in_sel = 1; a_in_data = 8'h33;
        #1;
        chk("t2_sel1_ready", a_in_ready, 1);
        tick();
        chk("t2_sel1_valid", a_out_valid, 4'b0110);
        chk("t2_sel1_data", a_out_data[15:8], 8'h33);
        a_in_sel = 2; a_in_data = 8'h22;
        #1;
        chk("t2_still_blocked", a_in_ready, 0);
        a_out_ready = 4'hF;
        #1;
        chk("t2_release_ready", a_in_ready, 1);
        chk("t2_first_out", a_out_data[23:16], 8'h11);
        tick();
        chk("t2_b2b_valid", a_out_valid, 4'b0100);
        chk("t2_b2b_data", a_out_data[23:16], 8'h22);
        a_in_valid = 0;
        tick();
        chk("t2_idle", a_out_valid, 0);

        // Broadcast blocked by a full, stalled slot 3.
        a_out_ready = 4'b0111; a_in_valid = 1; a_in_sel = 3; a_in_data = 8'h77;
        tick();
        chk("t3_slot3_full", a_out_valid, 4'b1000);
        a_in_bcast = 1; a_in_data = 8'h5A;
        #1;
        chk("t3_bc_blocked", a_in_ready, 0);
        tick();
        chk("t3_no_partial", a_out_valid, 4'b1000);
        chk("t3_slot3_kept", a_out_data[31:24], 8'h77);
        a_out_ready = 4'hF;
        #1;
        chk("t3_bc_ready", a_in_ready, 1);
        tick();
        chk("t3_bc_valid", a_out_valid, 4'hF);
        for (int k = 0; k < 4; k++) chk("t3_bc_data", a_out_data[k*8 +: 8], 8'h5A);
        a_in_valid = 0; a_in_bcast = 0;
        tick();
        chk("t3_idle", a_out_valid, 0);

        // Reset with slots occupied and a beat in flight.
        a_out_ready = 4'h0; a_in_valid = 1; a_in_sel = 0; a_in_data = 8'hC0;
        tick();
        a_in_sel = 1; a_in_data = 8'hC1;
        tick();
        chk("t5_filled", a_out_valid, 4'b0011);
        a_in_sel = 2; a_in_data = 8'hC2; a_rst_n = 0;
        #1;
        chk("t5_ready_in_reset", a_in_ready, 0);
        tick();
        a_rst_n = 1; a_in_valid = 0; a_out_ready = 4'hF;
        #1;
        chk("t5_valid_cleared", a_out_valid, 0);
        chk("t5_data_cleared", a_out_data, 0);
        chk("t5_drop_cleared", a_drop, 0);
        tick();
        chk("t5_no_ghost_beat", a_out_valid, 0);
    endtask

    task automatic run_b();
        int exp_drop;
        b_rst_n = 0; b_in_valid = 0; b_in_sel = 0; b_in_bcast = 0; b_in_data = 0; b_out_ready = '1;
        tick();
        tick();
        b_rst_n = 1;
        b_in_valid = 1; b_in_sel = 3; b_in_data = 8'hFF;
        #1;
        chk("t4_oob_ready", b_in_ready, 1);
        tick();
        b_in_valid = 0;
        #1;
        chk("t4_err_pulse", b_err, 1);
        chk("t4_drop_1", b_drop, 1);
        chk("t4_no_valid", b_out_valid, 0);
        tick();
        chk("t4_err_one_cycle", b_err, 0);
        chk("t4_drop_hold", b_drop, 1);
        exp_drop = 1;
        b_in_valid = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_drop = (exp_drop < 3) ? exp_drop + 1 : 3;
            chk("t4_drop_sat", b_drop, 64'(exp_drop));
            chk("t4_err_each", b_err, 1);
        end
        b_in_valid = 0;
        tick();
        chk("t4_err_end", b_err, 0);
        chk("t4_drop_final", b_drop, 3);
        chk("t4_no_valid_end", b_out_valid, 0);
    endtask

    task automatic run_c();
        int   acc;
        int   cyc;
        logic [CN-1:0] free;
        logic all_free;
        logic exp_rdy;
        acc = 0; cyc = 0;
        c_rst_n = 0; c_in_valid = 0; c_in_sel = 0; c_in_bcast = 0; c_in_data = 0; c_out_ready = '1;
        tick();
        tick();
        c_rst_n = 1;
        soak_on = 1;
        while (acc < 10000 && cyc < 60000) begin
            @(negedge clk);
            c_in_valid  = ($urandom_range(3) != 0);
            c_in_bcast  = ($urandom_range(7) == 0);
            c_in_sel    = 3'($urandom_range(7));
            c_in_data   = 8'($urandom);
            c_out_ready = 5'($urandom);
            #2;
            all_free = 1'b1;
            for (int k = 0; k < CN; k++) begin
                free[k]  = (exp_q[k].size() == 0) || c_out_ready[k];
                all_free = all_free & free[k];
            end
            if (c_in_bcast)          exp_rdy = all_free;
            else if (c_in_sel < CN)  exp_rdy = free[c_in_sel];
            else                     exp_rdy = 1'b1;
            chk("c_in_ready", c_in_ready, exp_rdy);
            c_err_m = 1'b0;
            if (c_in_valid && exp_rdy) begin
                acc++;
                if (c_in_bcast) begin
                    for (int k = 0; k < CN; k++) exp_q[k].push_back(c_in_data);
                end else if (c_in_sel < CN) begin
                    exp_q[c_in_sel].push_back(c_in_data);
                end else begin
                    c_err_m  = 1'b1;
                    c_drop_m = (c_drop_m < 255) ? c_drop_m + 1 : 255;
                end
            end
            cyc++;
        end
        chk("c_soak_beats", acc, 10000);
        repeat (4) begin
            @(negedge clk);
            c_in_valid  = 0;
            c_out_ready = '1;
            #2;
            c_err_m = 1'b0;
        end
        @(negedge clk);
        #3;
        soak_on = 0;
        for (int k = 0; k < CN; k++) chk("c_drained", exp_q[k].size(), 0);
    endtask

    // Monitor for instance C: checks every handshake against the model queues.
    logic [7:0]    prev_d [CN];
    logic [CN-1:0] prev_v = '0;
    logic [CN-1:0] prev_r = '0;

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (soak_on) begin
                for (int k = 0; k < CN; k++) begin
                    chk("c_valid", c_out_valid[k], exp_q[k].size() != 0);
                    if (prev_v[k] && !prev_r[k]) begin
                        chk("c_stable_valid", c_out_valid[k], 1);
                        chk("c_stable_data", c_out_data[k*8 +: 8], prev_d[k]);
                    end
                    if (c_out_valid[k] && c_out_ready[k]) begin
                        if (exp_q[k].size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL c_extra_beat ch%0d: got %0h expected no beat", k, c_out_data[k*8 +: 8]);
                        end else begin
                            chk("c_data", c_out_data[k*8 +: 8], exp_q[k].pop_front());
                        end
                    end
                    prev_d[k] = c_out_data[k*8 +: 8];
                end
                chk("c_err_pulse", c_err, c_err_m);
                chk("c_drop_cnt", c_drop, 64'(c_drop_m));
                prev_v = c_out_valid;
                prev_r = c_out_ready;
            end
        end
    end

    initial begin
        fork
            begin
                run_a();
                run_b();
            end
            run_c();
        join
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
